// File: rtl/huffman_decoder.sv
// Serial Huffman decoder: matches incoming bits against a host-loaded code table
// and queues decoded symbols in a FIFO that the host pops over Avalon-MM.
module huffman_decoder #(
    parameter int NSYM       = 64,
    parameter int MAXLEN     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        chipselect,
    input  logic        address,
    input  logic        write,
    input  logic        read,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        encoded_in,
    input  logic        enable_in,
    output logic        irq
);
    localparam int SYM_W = $clog2(NSYM);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [3:0]       MAXLEN_C = 4'(MAXLEN);
    localparam logic [CNT_W-1:0] FULL_C   = CNT_W'(FIFO_DEPTH);

    logic [3:0]        len_tab  [NSYM];
    logic [MAXLEN-1:0] code_tab [NSYM];
    logic [SYM_W-1:0]  fifo_mem [FIFO_DEPTH];

    logic [MAXLEN-1:0] acc, acc_next, nacc;
    logic [3:0]        cnt, cnt_next, ncnt;
    logic              err, err_next, ovf, ovf_next;
    logic [PTR_W-1:0]  wptr, rptr, wptr_next, rptr_next;
    logic [CNT_W-1:0]  count, count_next;
    logic              tab_wr, ctl_wr, rd_any, shift_bit, hit, push, push_ok, pop, flush;
    logic              nonempty;
    logic [SYM_W-1:0]  hit_idx, head;
    logic [3:0]        wr_len;
    logic [31:0]       status_word;
    logic              unused_wd;

    assign unused_wd = ^writedata[31:10+MAXLEN];

    function automatic logic [MAXLEN-1:0] len_mask(input logic [3:0] len);
        logic [MAXLEN:0] ones;
        ones = ((MAXLEN+1)'(1) << len) - (MAXLEN+1)'(1);
        return ones[MAXLEN-1:0];
    endfunction

    assign tab_wr    = chipselect & write & ~address;
    assign ctl_wr    = chipselect & write & address;
    assign rd_any    = chipselect & read & ~write;
    assign flush     = ctl_wr & writedata[1];
    // Any control write owns the cycle; a coincident serial bit is dropped.
    assign shift_bit = enable_in & ~ctl_wr;
    assign nacc      = {acc[MAXLEN-2:0], encoded_in};
    assign ncnt      = cnt + 4'd1;
    assign nonempty  = (count != '0);
    assign head      = fifo_mem[rptr];
    assign wr_len    = (writedata[9:6] > MAXLEN_C) ? 4'd0 : writedata[9:6];

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NSYM - 1; i >= 0; i--) begin
            if (len_tab[i] == ncnt &&
                ((code_tab[i] ^ nacc) & len_mask(len_tab[i])) == '0) begin
                hit     = 1'b1;
                hit_idx = SYM_W'(i);
            end
        end
    end

    always_comb begin
        acc_next = acc;
        cnt_next = cnt;
        err_next = err;
        ovf_next = ovf;
        push     = 1'b0;
        if (ctl_wr && writedata[0]) begin
            acc_next = '0;
            cnt_next = '0;
            err_next = 1'b0;
            ovf_next = 1'b0;
        end else if (shift_bit) begin
            if (hit) begin
                push     = 1'b1;
                acc_next = '0;
                cnt_next = '0;
            end else if (ncnt == MAXLEN_C) begin
                err_next = 1'b1;
                acc_next = '0;
                cnt_next = '0;
            end else begin
                acc_next = nacc;
                cnt_next = ncnt;
            end
        end

        pop     = rd_any & ~address & nonempty;
        push_ok = push & ((count != FULL_C) | pop);
        if (push && !push_ok)
            ovf_next = 1'b1;

        wptr_next  = wptr;
        rptr_next  = rptr;
        count_next = count;
        if (flush) begin
            wptr_next  = '0;
            rptr_next  = '0;
            count_next = '0;
        end else begin
            if (push_ok) wptr_next = wptr + PTR_W'(1);
            if (pop)     rptr_next = rptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count_next = count + CNT_W'(1);
                2'b01:   count_next = count - CNT_W'(1);
                default: count_next = count;
            endcase
        end
    end

    assign status_word = {12'b0, 4'(count), 6'b0, ovf, err, nonempty, 1'b0,
                          nonempty ? 6'(head) : 6'b0};

    always_ff @(posedge clock) begin
        if (!resetn) begin
            acc      <= '0;
            cnt      <= '0;
            err      <= 1'b0;
            ovf      <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            acc   <= acc_next;
            cnt   <= cnt_next;
            err   <= err_next;
            ovf   <= ovf_next;
            wptr  <= wptr_next;
            rptr  <= rptr_next;
            count <= count_next;
            if (rd_any)
                readdata <= status_word;
            irq <= (count_next != '0) | err_next | ovf_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < NSYM; i++) begin
                len_tab[i]  <= '0;
                code_tab[i] <= '0;
            end
        end else if (tab_wr) begin
            len_tab[writedata[SYM_W-1:0]]  <= wr_len;
            code_tab[writedata[SYM_W-1:0]] <= writedata[10 +: MAXLEN];
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok)
            fifo_mem[wptr] <= hit_idx;
    end
endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder; reads push expected words into a queue that a
// monitor checks against registered readdata.
module tb_huffman_decoder;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        chipselect = 1'b0, address = 1'b0, write = 1'b0, read = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        encoded_in = 1'b0, enable_in = 1'b0;
    logic        irq;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic        pend = 1'b0;

    always #5 clock = ~clock;

    huffman_decoder dut (
        .clock      (clock),
        .resetn     (resetn),
        .chipselect (chipselect),
        .address    (address),
        .write      (write),
        .read       (read),
        .writedata  (writedata),
        .readdata   (readdata),
        .encoded_in (encoded_in),
        .enable_in  (enable_in),
        .irq        (irq)
    );

    function automatic logic [31:0] rdx(input int cnt, input bit ov, input bit er,
                                        input bit vld, input int sym);
        logic [3:0] c;
        logic [5:0] s;
        c = 4'(cnt);
        s = 6'(sym);
        return {12'b0, c, 6'b0, ov, er, vld, 1'b0, s};
    endfunction

    task automatic check(input logic [31:0] act, input logic [31:0] exp, input string tag);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, act, exp);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic cs, input logic wr, input logic rd, input logic adr,
                         input logic [31:0] wd, input logic en, input logic b);
        chipselect = cs; write = wr; read = rd; address = adr;
        writedata = wd; enable_in = en; encoded_in = b;
        tick;
        chipselect = 1'b0; write = 1'b0; read = 1'b0; address = 1'b0;
        writedata = '0; enable_in = 1'b0; encoded_in = 1'b0;
    endtask

    task automatic do_reset;
        resetn = 1'b0;
        tick;
        tick;
        resetn = 1'b1;
    endtask

    task automatic tab_wr(input int sym, input int len, input int code);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'((code << 10) | (len << 6) | sym), 1'b0, 1'b0);
    endtask

    task automatic ctl_wr(input int v);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'(v), 1'b0, 1'b0);
    endtask

    task automatic send(input logic b);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, b);
    endtask

    task automatic bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send(v[i]);
    endtask

    task automatic rd(input logic adr, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        drive(1'b1, 1'b0, 1'b1, adr, '0, 1'b0, 1'b0);
    endtask

    task automatic chk_irq(input bit e, input string tag);
        check(32'(irq), 32'(e), tag);
    endtask

    // Monitor: a read accepted at an edge has its data on readdata after that edge.
    always @(posedge clock) pend <= chipselect & read & ~write;

    always @(negedge clock) begin
        if (pend) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_read: got %h, expected no response", readdata);
            end else begin
                logic [31:0] e;
                string       t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check(readdata, e, t);
            end
        end
    end

    initial begin
        tick;
        do_reset;
        rd(1'b1, 32'h0, "reset_status");
        chk_irq(1'b0, "reset_irq");

        // single symbol
        tab_wr(5, 3, 3'b101);
        bits(8'b101, 3);
        chk_irq(1'b1, "single_irq");
        rd(1'b0, rdx(1, 0, 0, 1, 5), "single_sym");
        chk_irq(1'b0, "single_irq_clear");
        rd(1'b0, rdx(0, 0, 0, 0, 0), "single_empty");

        // prefix stream 0 | 10 | 11 | 0 with idle gaps
        tab_wr(0, 1, 0);
        tab_wr(1, 2, 2'b10);
        tab_wr(2, 2, 2'b11);
        send(1'b0); tick;
        send(1'b1); send(1'b0); tick; tick;
        send(1'b1); send(1'b1); tick;
        send(1'b0);
        rd(1'b0, rdx(4, 0, 0, 1, 0), "prefix_0");
        rd(1'b0, rdx(3, 0, 0, 1, 1), "prefix_1");
        rd(1'b0, rdx(2, 0, 0, 1, 2), "prefix_2");
        rd(1'b0, rdx(1, 0, 0, 1, 0), "prefix_3");

        // error after MAXLEN unmatched bits
        do_reset;
        tab_wr(0, 2, 2'b00);
        bits(8'hFF, 8);
        rd(1'b1, rdx(0, 0, 1, 0, 0), "err_status");
        chk_irq(1'b1, "err_irq");
        bits(8'b00, 2);
        rd(1'b0, rdx(1, 0, 1, 1, 0), "err_then_sym");
        ctl_wr(1);
        rd(1'b1, rdx(0, 0, 0, 0, 0), "err_cleared");
        chk_irq(1'b0, "err_irq_clear");

        // overflow: sym1 then seven sym0 fill the FIFO, ninth (sym1) is dropped
        tab_wr(1, 2, 2'b01);
        bits(8'b01, 2);
        for (int k = 0; k < 7; k++) bits(8'b00, 2);
        bits(8'b01, 2);
        rd(1'b1, rdx(8, 1, 0, 1, 1), "ovf_status");
        send(1'b0);
        exp_q.push_back(rdx(8, 1, 0, 1, 1));
        tag_q.push_back("ovf_pop_with_push");
        drive(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
        rd(1'b1, rdx(8, 1, 0, 1, 0), "ovf_count_kept");
        for (int k = 0; k < 7; k++) rd(1'b0, rdx(8 - k, 1, 0, 1, 0), "ovf_drain");
        rd(1'b0, rdx(1, 1, 0, 1, 1), "ovf_last_pushed");
        ctl_wr(1);
        rd(1'b1, rdx(0, 0, 0, 0, 0), "ovf_cleared");
        chk_irq(1'b0, "ovf_irq_clear");

        // FIFO flush
        bits(8'b00, 2);
        bits(8'b01, 2);
        chk_irq(1'b1, "flush_irq_before");
        ctl_wr(2);
        rd(1'b1, rdx(0, 0, 0, 0, 0), "flush_status");
        chk_irq(1'b0, "flush_irq_after");

        // mid-stream clear
        tab_wr(7, 3, 3'b110);
        send(1'b1); send(1'b1);
        ctl_wr(1);
        bits(8'b110, 3);
        rd(1'b0, rdx(1, 0, 0, 1, 7), "clear_mid");
        rd(1'b0, rdx(0, 0, 0, 0, 0), "clear_mid_once");
        send(1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'd1, 1'b1, 1'b1);
        bits(8'b110, 3);
        rd(1'b0, rdx(1, 0, 0, 1, 7), "clear_beats_bit");
        rd(1'b0, rdx(0, 0, 0, 0, 0), "clear_beats_bit_once");

        // mid-stream reset, then empty-table behaviour
        send(1'b1); send(1'b1);
        do_reset;
        tab_wr(7, 3, 3'b110);
        bits(8'b110, 3);
        rd(1'b0, rdx(1, 0, 0, 1, 7), "reset_mid");
        rd(1'b1, rdx(0, 0, 0, 0, 0), "reset_mid_once");
        do_reset;
        bits(8'b110, 3);
        rd(1'b1, rdx(0, 0, 0, 0, 0), "reset_table_empty");
        chk_irq(1'b0, "reset_table_irq");

        tick;
        tick;
        check(32'(exp_q.size()), 32'd0, "queue_drained");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
